multi_channel_edge_sampler: RTL
===============================

MULTI_CHANNEL_EDGE_SAMPLER -- requirements
Module: multi_channel_edge_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and captured-value width.
REQ-002 SHALL have parameter CHANNELS, default 4 (2..16): number of comparator inputs.
REQ-003 SHALL have parameter DEPTH, default 8 (power of 2, >=2): output FIFO entries.
REQ-004 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port comp, input, CHANNELS: per-channel comparator outputs, synchronous to clk.
REQ-007 SHALL have port counter, input, WIDTH: free-running count value to capture.
REQ-008 SHALL have port arm, input, 1: edge detection enable.
REQ-009 SHALL have port edge_mode, input, 2: 00 rising, 01 falling, 10 both, 11 none.
REQ-010 SHALL have port flush, input, 1: synchronous clear of pending entries and FIFO.
REQ-011 SHALL have port out_valid, output, 1: FIFO head valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accept.
REQ-013 SHALL have port out_chan, output, clog2(CHANNELS): head channel index.
REQ-014 SHALL have port out_count, output, WIDTH: head captured counter.
REQ-015 SHALL have port out_rise, output, 1: head edge polarity (1 rising, 0 falling).
REQ-016 SHALL have port overflow, output, 1: sticky; an edge was dropped.

Function
REQ-017 SHALL register comp into comp_d every cycle, regardless of arm, so arming never creates a false edge.
REQ-018 SHALL detect on channel i a rising edge as comp[i]&~comp_d[i], falling as ~comp[i]&comp_d[i], qualified by arm and edge_mode.
REQ-019 SHALL, on a qualified edge at clock edge k, load channel i's pending slot with {counter sampled at k, polarity}.
REQ-020 SHALL, each cycle, move at most one pending slot into the FIFO: lowest-index pending channel wins, only if FIFO not full.
REQ-021 SHALL present an entry as out_valid from the edge after its FIFO write: comp edge at k -> out_valid at earliest after k+1 (2-cycle latency).
REQ-022 SHALL provide a show-ahead FIFO: out_chan/out_count/out_rise valid whenever out_valid=1; pop on out_valid&out_ready.
REQ-023 SHALL allow a push and a pop in the same cycle when full; occupancy unchanged.
REQ-024 SHALL, on a qualified edge while that channel's slot stays pending (not transferred this cycle), drop the new edge, keep the old entry, and set overflow.
REQ-025 SHALL, when the slot transfers in the same cycle as a new qualified edge, reload the slot with the new edge (no drop).
REQ-026 SHALL, with FIFO full, keep all pending slots held; only new edges on held channels are dropped.
REQ-027 SHALL, on flush, clear all pending slots and FIFO pointers and overflow next cycle; edges coincident with flush are discarded.
REQ-028 SHALL wrap FIFO pointers modulo DEPTH with an extra wrap bit for full/empty.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear comp_d, pending slots, FIFO pointers, overflow; out_valid=0, out_chan=0, out_count=0, out_rise=0.
REQ-030 SHALL discard all in-flight entries when reset asserts mid-operation; first edge after release is judged against comp_d=0.

Configuration
REQ-031 SHALL, with SAMPLER_DROP_COUNT_EN defined, add output drop_count (8 bits) counting dropped edges, saturating at 255, cleared by reset and flush.
REQ-032 SHALL, without SAMPLER_DROP_COUNT_EN, omit drop_count port and logic; overflow behaviour unchanged.

Verification
REQ-033 SHALL test: arm=1, mode=00, comp[2] rises with counter=0x35, out_ready=1 -> out_valid two cycles later, chan=2, count=0x35, rise=1.
REQ-034 SHALL test: comp[0] and comp[3] rise same cycle, counter=0x10 -> entries chan 0 then chan 3, both count 0x10, consecutive cycles.
REQ-035 SHALL test: mode=10, comp[1] pulses high 3 cycles at counter=0x20 -> entries (1,0x20,rise) then (1,0x23,fall).
REQ-036 SHALL test: out_ready=0, DEPTH+2 edges on channel 0 spaced 2 cycles -> DEPTH entries kept, overflow=1, drop_count=1 if enabled.
REQ-037 SHALL test: comp[1]=1 while arm=0, then arm=1 -> no entry; flush with FIFO non-empty -> out_valid=0, overflow=0 next cycle.
REQ-038 SHALL test: rst_n low mid-stream with 3 queued entries -> out_valid=0 immediately, no stale entry after release.

Source files
------------

// File: rtl/multi_channel_edge_sampler.sv
// multi_channel_edge_sampler
// Watches CHANNELS comparator inputs. On each qualified edge it captures the
// free-running counter value and the edge polarity into a per-channel pending
// slot. Each cycle, one pending slot (lowest channel index first) moves into
// a show-ahead output FIFO.
// Optional feature: define SAMPLER_DROP_COUNT_EN to add an 8-bit saturating
// drop_count output that counts dropped edges.
module multi_channel_edge_sampler #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS-1:0]         comp,
  input  logic [WIDTH-1:0]            counter,
  input  logic                        arm,
  input  logic [1:0]                  edge_mode,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(CHANNELS)-1:0] out_chan,
  output logic [WIDTH-1:0]            out_count,
  output logic                        out_rise,
  output logic                        overflow
`ifdef SAMPLER_DROP_COUNT_EN
  ,
  output logic [7:0]                  drop_count
`endif
);

  localparam int CW = $clog2(CHANNELS);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + WIDTH + 1;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } edge_mode_e;

  edge_mode_e          mode;
  logic [CHANNELS-1:0] comp_d;
  logic [CHANNELS-1:0] rise_ev;
  logic [CHANNELS-1:0] fall_ev;
  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] xfer;
  logic [CHANNELS-1:0] drop;

  logic [CHANNELS-1:0] pend_valid;
  logic [CHANNELS-1:0] pend_rise;
  logic [WIDTH-1:0]    pend_count [CHANNELS];

  logic                sel_found;
  logic [CW-1:0]       sel_idx;

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       head;

  assign mode = edge_mode_e'(edge_mode);

  // Delayed copy of the comparator inputs; runs even while disarmed so that
  // arming later never sees a stale level as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) comp_d <= '0;
    else        comp_d <= comp;
  end

  // Edge detection qualified by arm and the selected edge polarity.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    rise_ev = comp & ~comp_d;
    fall_ev = ~comp & comp_d;
    qual    = '0;
    if (arm) begin
      case (mode)
        MODE_RISE: qual = rise_ev;
        MODE_FALL: qual = fall_ev;
        MODE_BOTH: qual = rise_ev | fall_ev;
        default:   qual = '0;
      endcase
    end
  end

  // Lowest-index pending channel wins the single FIFO write port.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend_valid[i]) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_valid & out_ready & ~flush;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push  = sel_found & (~full | pop) & ~flush;

  // Per-channel transfer strobe and edge-drop detection.
  always_comb begin
    xfer = '0;
    drop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      xfer[i] = push && (sel_idx == CW'(i));
      drop[i] = qual[i] && pend_valid[i] && !xfer[i] && !flush;
    end
  end

  // Pending slots: a qualified edge loads the slot if it is free or leaving
  // this cycle; otherwise the older capture is kept and the new edge is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= '0;
      pend_rise  <= '0;
      for (int i = 0; i < CHANNELS; i++) pend_count[i] <= '0;
    end else if (flush) begin
      pend_valid <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (qual[i] && (!pend_valid[i] || xfer[i])) begin
          pend_valid[i] <= 1'b1;
          pend_count[i] <= counter;
          pend_rise[i]  <= rise_ev[i];
        end else if (xfer[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers carry an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage written with {channel, captured count, polarity}.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are live and the outputs are masked while the FIFO is empty.
    if (push) mem[wr_ptr[AW-1:0]] <= {sel_idx, pend_count[sel_idx], pend_rise[sel_idx]};
  end

  // Sticky overflow: any dropped edge sets it until flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     overflow <= 1'b0;
    else if (flush) overflow <= 1'b0;
    else if (|drop) overflow <= 1'b1;
  end

`ifdef SAMPLER_DROP_COUNT_EN
  logic [8:0] drop_num;
  logic [8:0] drop_sum;

  // Number of edges dropped this cycle added onto the running total.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (drop[i]) drop_num = drop_num + 9'd1;
    end
    drop_sum = {1'b0, drop_count} + drop_num;
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           drop_count <= '0;
    else if (flush)       drop_count <= '0;
    else if (drop_sum[8]) drop_count <= 8'hFF;
    else                  drop_count <= drop_sum[7:0];
  end
`endif

  // Show-ahead head; fields read as zero while nothing is queued.
  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = ~empty;
  assign out_chan  = out_valid ? head[EW-1 -: CW] : '0;
  assign out_count = out_valid ? head[WIDTH:1]    : '0;
  assign out_rise  = out_valid & head[0];

endmodule
